// File: rtl/qdr_write_arbiter.sv
// Round-robin arbiter that funnels per-port write bursts into a single QDR write port.
// Define QDR_WRITE_ARBITER_STATS_EN to enable the stat_bursts/stat_words counters.
module qdr_write_arbiter #(
   parameter int NUM_PORTS = 15,
   parameter int ADDR_BITS = 18,
   parameter int DATA_BITS = 144,
   parameter int MAX_BURST = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_PORTS-1:0]           port_wr_req,
   input  logic [NUM_PORTS-1:0]           port_wr_valid,
   input  logic [NUM_PORTS-1:0]           port_wr_last,
   input  logic [NUM_PORTS*ADDR_BITS-1:0] port_wr_addr,
   input  logic [NUM_PORTS*DATA_BITS-1:0] port_wr_data,
   output logic [NUM_PORTS-1:0]           port_wr_grant,
   output logic                           ram_wr_en,
   output logic [ADDR_BITS-1:0]           ram_wr_addr,
   output logic [DATA_BITS-1:0]           ram_wr_data,
   output logic                           burst_capped,
   output logic [31:0]                    stat_bursts,
   output logic [31:0]                    stat_words
);

   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_PORTS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                 state_q, state_d;
   logic [NUM_PORTS-1:0]   grant_q, grant_d;
   logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   wr_en_q, wr_en_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   capped_q, capped_d;
   logic [PTR_W-1:0]       pick;
   logic                   pick_vld;

   // Scan downward so the last hit is the first requester above rr_ptr.
   always_comb begin : rr_pick
      int               idx;
      logic [PTR_W-1:0] cand;
      idx      = 0;
      cand     = '0;
      pick     = rr_ptr_q;
      pick_vld = 1'b0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         cand = PTR_W'(idx);
         if (port_wr_req[cand]) begin
            pick     = cand;
            pick_vld = 1'b1;
         end
      end
   end

   // While in BURST, rr_ptr_q holds the granted port index.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      wr_en_d  = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;
      capped_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d  = BURST;
               grant_d  = NUM_PORTS'(1) << pick;
               rr_ptr_d = pick;
               cnt_d    = '0;
            end
         end
         BURST: begin
            if (port_wr_valid[rr_ptr_q]) begin
               wr_en_d = 1'b1;
               addr_d  = port_wr_addr[rr_ptr_q*ADDR_BITS +: ADDR_BITS];
               data_d  = port_wr_data[rr_ptr_q*DATA_BITS +: DATA_BITS];
               cnt_d   = cnt_q + 1'b1;
               if (port_wr_last[rr_ptr_q] || (cnt_q == CNT_LAST)) begin
                  state_d  = IDLE;
                  grant_d  = '0;
                  capped_d = ~port_wr_last[rr_ptr_q];
               end
            end else if (!port_wr_req[rr_ptr_q]) begin
               state_d = IDLE;
               grant_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= PTR_RST;
         cnt_q    <= '0;
         wr_en_q  <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         capped_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         wr_en_q  <= wr_en_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         capped_q <= capped_d;
      end
   end

   assign port_wr_grant = grant_q;
   assign ram_wr_en     = wr_en_q;
   assign ram_wr_addr   = addr_q;
   assign ram_wr_data   = data_q;
   assign burst_capped  = capped_q;

`ifdef QDR_WRITE_ARBITER_STATS_EN
   logic [31:0] stat_bursts_q, stat_bursts_d;
   logic [31:0] stat_words_q, stat_words_d;

   // Both counters saturate at all-ones.
   always_comb begin
      stat_bursts_d = stat_bursts_q;
      stat_words_d  = stat_words_q;
      if ((state_q == IDLE) && pick_vld && (stat_bursts_q != '1))
         stat_bursts_d = stat_bursts_q + 32'd1;
      if ((state_q == BURST) && port_wr_valid[rr_ptr_q] && (stat_words_q != '1))
         stat_words_d = stat_words_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_bursts_q <= '0;
         stat_words_q  <= '0;
      end else begin
         stat_bursts_q <= stat_bursts_d;
         stat_words_q  <= stat_words_d;
      end
   end

   assign stat_bursts = stat_bursts_q;
   assign stat_words  = stat_words_q;
`else
   assign stat_bursts = '0;
   assign stat_words  = '0;
`endif

endmodule

// File: tb/tb_qdr_write_arbiter.sv
// Directed-vector bench for qdr_write_arbiter: grant timing, round robin, capping, bubbles, abort, reset.
module tb_qdr_write_arbiter;

   localparam int NP = 15;
   localparam int AB = 18;
   localparam int DB = 144;
   localparam int MB = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NP-1:0]     req, valid, last;
   logic [NP*AB-1:0]  addr;
   logic [NP*DB-1:0]  data;
   logic [NP-1:0]     grant;
   logic              en;
   logic [AB-1:0]     waddr;
   logic [DB-1:0]     wdata;
   logic              capped;
   logic [31:0]       sb, sw;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   qdr_write_arbiter #(
      .NUM_PORTS (NP),
      .ADDR_BITS (AB),
      .DATA_BITS (DB),
      .MAX_BURST (MB)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .port_wr_req   (req),
      .port_wr_valid (valid),
      .port_wr_last  (last),
      .port_wr_addr  (addr),
      .port_wr_data  (data),
      .port_wr_grant (grant),
      .ram_wr_en     (en),
      .ram_wr_addr   (waddr),
      .ram_wr_data   (wdata),
      .burst_capped  (capped),
      .stat_bursts   (sb),
      .stat_words    (sw)
   );

   function automatic logic [DB-1:0] mkdata(input logic [AB-1:0] a);
      return {8{a}};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Present word w of port p; every other port has valid/last low.
   task automatic apply(input logic [NP-1:0] rmask, input int p, input logic v,
                        input logic l, input int w);
      req = rmask;
      valid = '0;
      last = '0;
      valid[p] = v;
      last[p] = l;
      addr[p*AB +: AB] = AB'(p*256 + w);
      data[p*DB +: DB] = mkdata(AB'(p*256 + w));
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = '1;
      valid = '1;
      last = '0;
      addr = '1;
      data = '1;
      step();
      step();
      vec_cnt++;
      if (grant !== '0 || en !== 1'b0 || capped !== 1'b0 || waddr !== '0 || wdata !== '0) begin
         err_cnt++;
         $display("FAIL reset_state: got g=%h en=%b cap=%b a=%h, want all zero", grant, en, capped, waddr);
      end
      vec_cnt++;
      if (sb !== 32'd0 || sw !== 32'd0) begin
         err_cnt++;
         $display("FAIL reset_stats: got bursts=%0d words=%0d, want 0 0", sb, sw);
      end
      req = '0;
      valid = '0;
      #2 rst = 1'b0;
      step();
      vec_cnt++;
      if (grant !== '0 || en !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_release: got g=%h en=%b, want g=0 en=0", grant, en);
      end
   endtask

   task automatic test_two_ports();
      bit [NP-1:0] s_req  [9] = '{15'h009, 15'h009, 15'h009, 15'h009, 15'h008, 15'h008, 15'h008, 15'h008, 15'h000};
      int          s_port [9] = '{0, 0, 0, 0, 3, 3, 3, 3, 0};
      int          s_word [9] = '{0, 0, 1, 2, 0, 0, 1, 2, 0};
      bit          s_vld  [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
      bit          s_last [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
      bit [NP-1:0] e_g    [9] = '{15'h001, 15'h001, 15'h001, 15'h000, 15'h008, 15'h008, 15'h008, 15'h000, 15'h000};
      bit          e_en   [9] = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
      bit [AB-1:0] e_a    [9] = '{18'h000, 18'h000, 18'h001, 18'h002, 18'h002, 18'h300, 18'h301, 18'h302, 18'h302};
      for (int k = 0; k < 9; k++) begin
         apply(s_req[k], s_port[k], s_vld[k], s_last[k], s_word[k]);
         step();
         vec_cnt++;
         if (grant !== e_g[k] || en !== e_en[k] || waddr !== e_a[k] || wdata !== mkdata(e_a[k]) || capped !== 1'b0) begin
            err_cnt++;
            $display("FAIL two_ports k=%0d: got g=%h en=%b a=%h cap=%b, want g=%h en=%b a=%h cap=0",
                     k, grant, en, waddr, capped, e_g[k], e_en[k], e_a[k]);
         end
      end
   endtask

   task automatic test_capped();
      int          w;
      int          len;
      logic [AB-1:0] prev;
      logic [AB-1:0] ea;
      logic [NP-1:0] eg;
      logic          ec;
      do_reset();
      w = 0;
      apply(15'h020, 5, 1'b1, 1'b0, 0);
      for (int b = 0; b < 3; b++) begin
         len = (b == 2) ? 4 : 8;
         prev = (w == 0) ? '0 : AB'(32'h500 + w - 1);
         step();
         vec_cnt++;
         if (grant !== 15'h020 || en !== 1'b0 || waddr !== prev || capped !== 1'b0) begin
            err_cnt++;
            $display("FAIL capped_grant b=%0d: got g=%h en=%b a=%h cap=%b, want g=020 en=0 a=%h cap=0",
                     b, grant, en, waddr, capped, prev);
         end
         for (int j = 0; j < len; j++) begin
            step();
            ea = AB'(32'h500 + w);
            eg = (j == len - 1) ? '0 : 15'h020;
            ec = (j == len - 1) && (b < 2);
            vec_cnt++;
            if (en !== 1'b1 || waddr !== ea || wdata !== mkdata(ea) || grant !== eg || capped !== ec) begin
               err_cnt++;
               $display("FAIL capped_word w=%0d: got en=%b a=%h g=%h cap=%b, want en=1 a=%h g=%h cap=%b",
                        w, en, waddr, grant, capped, ea, eg, ec);
            end
            w++;
            if (w == 20) apply('0, 5, 1'b0, 1'b0, 0);
            else apply(15'h020, 5, 1'b1, (w == 19), w);
         end
      end
      step();
      vec_cnt++;
      if (grant !== '0 || en !== 1'b0 || capped !== 1'b0) begin
         err_cnt++;
         $display("FAIL capped_end: got g=%h en=%b cap=%b, want 0 0 0", grant, en, capped);
      end
`ifdef QDR_WRITE_ARBITER_STATS_EN
      vec_cnt++;
      if (sb !== 32'd3 || sw !== 32'd20) begin
         err_cnt++;
         $display("FAIL stats: got bursts=%0d words=%0d, want 3 20", sb, sw);
      end
`else
      vec_cnt++;
      if (sb !== 32'd0 || sw !== 32'd0) begin
         err_cnt++;
         $display("FAIL stats: got bursts=%0d words=%0d, want 0 0", sb, sw);
      end
`endif
   endtask

   task automatic test_all_ports();
      int            p;
      logic [AB-1:0] prev;
      do_reset();
      req = '1;
      valid = '1;
      last = '1;
      for (int q = 0; q < NP; q++) begin
         addr[q*AB +: AB] = AB'(q*256);
         data[q*DB +: DB] = mkdata(AB'(q*256));
      end
      prev = '0;
      for (int i = 0; i < 16; i++) begin
         p = i % NP;
         step();
         vec_cnt++;
         if (grant !== (NP'(1) << p) || en !== 1'b0 || waddr !== prev) begin
            err_cnt++;
            $display("FAIL rr_grant i=%0d: got g=%h en=%b a=%h, want g=%h en=0 a=%h",
                     i, grant, en, waddr, NP'(1) << p, prev);
         end
         step();
         prev = AB'(p*256);
         vec_cnt++;
         if (grant !== '0 || en !== 1'b1 || waddr !== prev || wdata !== mkdata(prev) || capped !== 1'b0) begin
            err_cnt++;
            $display("FAIL rr_write i=%0d: got g=%h en=%b a=%h cap=%b, want g=0 en=1 a=%h cap=0",
                     i, grant, en, waddr, capped, prev);
         end
      end
      req = '0;
      valid = '0;
      last = '0;
      step();
   endtask

   task automatic test_bubbles();
      bit [NP-1:0] s_req  [7] = '{15'h004, 15'h004, 15'h004, 15'h004, 15'h004, 15'h004, 15'h000};
      bit          s_vld  [7] = '{0, 1, 0, 0, 1, 1, 0};
      bit          s_last [7] = '{0, 0, 0, 0, 0, 1, 0};
      int          s_word [7] = '{0, 0, 1, 1, 1, 2, 0};
      bit [NP-1:0] e_g    [7] = '{15'h004, 15'h004, 15'h004, 15'h004, 15'h004, 15'h000, 15'h000};
      bit          e_en   [7] = '{0, 1, 0, 0, 1, 1, 0};
      bit [AB-1:0] e_a    [7] = '{18'h000, 18'h200, 18'h200, 18'h200, 18'h201, 18'h202, 18'h202};
      for (int k = 0; k < 7; k++) begin
         apply(s_req[k], 2, s_vld[k], s_last[k], s_word[k]);
         step();
         vec_cnt++;
         if (grant !== e_g[k] || en !== e_en[k] || waddr !== e_a[k] || wdata !== mkdata(e_a[k]) || capped !== 1'b0) begin
            err_cnt++;
            $display("FAIL bubbles k=%0d: got g=%h en=%b a=%h cap=%b, want g=%h en=%b a=%h cap=0",
                     k, grant, en, waddr, capped, e_g[k], e_en[k], e_a[k]);
         end
      end
   endtask

   task automatic test_abort();
      apply(15'h040, 6, 1'b0, 1'b0, 0);
      step();
      vec_cnt++;
      if (grant !== 15'h040 || en !== 1'b0) begin
         err_cnt++;
         $display("FAIL abort_grant: got g=%h en=%b, want g=040 en=0", grant, en);
      end
      apply('0, 6, 1'b0, 1'b0, 0);
      step();
      vec_cnt++;
      if (grant !== '0 || en !== 1'b0 || capped !== 1'b0 || waddr !== 18'h202) begin
         err_cnt++;
         $display("FAIL abort_drop: got g=%h en=%b cap=%b a=%h, want g=0 en=0 cap=0 a=00202",
                  grant, en, capped, waddr);
      end
      step();
      vec_cnt++;
      if (grant !== '0 || en !== 1'b0) begin
         err_cnt++;
         $display("FAIL abort_idle: got g=%h en=%b, want g=0 en=0", grant, en);
      end
   endtask

   task automatic test_reset_midburst();
      apply(15'h010, 4, 1'b1, 1'b0, 0);
      step();
      vec_cnt++;
      if (grant !== 15'h010) begin
         err_cnt++;
         $display("FAIL midrst_grant: got g=%h, want g=010", grant);
      end
      for (int j = 0; j < 3; j++) begin
         step();
         vec_cnt++;
         if (grant !== 15'h010 || en !== 1'b1 || waddr !== AB'(32'h400 + j)) begin
            err_cnt++;
            $display("FAIL midrst_word j=%0d: got g=%h en=%b a=%h, want g=010 en=1 a=%h",
                     j, grant, en, waddr, AB'(32'h400 + j));
         end
         apply(15'h010, 4, 1'b1, 1'b0, j + 1);
      end
      rst = 1'b1;
      #1;
      vec_cnt++;
      if (grant !== '0 || en !== 1'b0 || capped !== 1'b0 || waddr !== '0 || wdata !== '0) begin
         err_cnt++;
         $display("FAIL midrst_async: got g=%h en=%b cap=%b a=%h, want all zero", grant, en, capped, waddr);
      end
      req = 15'h011;
      valid[0] = 1'b0;
      step();
      vec_cnt++;
      if (grant !== '0 || en !== 1'b0) begin
         err_cnt++;
         $display("FAIL midrst_hold: got g=%h en=%b, want g=0 en=0", grant, en);
      end
      rst = 1'b0;
      step();
      vec_cnt++;
      if (grant !== 15'h001 || en !== 1'b0) begin
         err_cnt++;
         $display("FAIL midrst_release: got g=%h en=%b, want g=001 en=0", grant, en);
      end
      apply('0, 0, 1'b0, 1'b0, 0);
      step();
      vec_cnt++;
      if (grant !== '0 || en !== 1'b0) begin
         err_cnt++;
         $display("FAIL midrst_cleanup: got g=%h en=%b, want g=0 en=0", grant, en);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      req = '0;
      valid = '0;
      last = '0;
      addr = '0;
      data = '0;
      test_reset();
      test_two_ports();
      test_capped();
      test_all_ports();
      test_bubbles();
      test_abort();
      test_reset_midburst();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
